// File: rtl/tof_pkg.sv
// Shared types and defaults for the time-of-flight echo timer.
package tof_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        LISTEN
    } state_t;

    localparam int CNT_WIDTH_DEFAULT = 24;

endpackage

// File: rtl/tof_echo_timer_echo_qualifier.sv
// Echo edge detector and run-length qualifier: flags a rising echo edge and
// accepts it once the echo has stayed high for ECHO_MIN consecutive samples.
module echo_qualifier #(
    parameter int ECHO_MIN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    input  logic eligible_i,
    input  logic echo_i,
    output logic rise_pulse_o,
    output logic accept_o
);

    localparam int RunWidth = $clog2(ECHO_MIN + 1);

    logic                prev_q;
    logic [RunWidth-1:0] run_q;
    logic [RunWidth-1:0] run_d;

    // A rise always follows a low sample, so an active run can never overlap a new rise.
    always_comb begin
        rise_pulse_o = enable_i && eligible_i && echo_i && !prev_q;
        run_d        = '0;
        if (rise_pulse_o) begin
            run_d = RunWidth'(1);
        end else if ((run_q != '0) && echo_i) begin
            run_d = run_q + RunWidth'(1);
        end
        accept_o = enable_i && (run_d == RunWidth'(ECHO_MIN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            run_q  <= '0;
        end else if (clear_i) begin
            prev_q <= echo_i;
            run_q  <= '0;
        end else if (enable_i) begin
            prev_q <= echo_i;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/tof_echo_timer.sv
// Measures clk cycles from a transmit-start strobe to the first qualified
// echo rise, with blanking, glitch rejection, timeout and abort.
module tof_echo_timer
    import tof_pkg::*;
#(
    parameter int CNT_WIDTH    = CNT_WIDTH_DEFAULT,
    parameter int BLANK_CYCLES = 100,
    parameter int ECHO_MIN     = 3,
    parameter int MAX_CYCLES   = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 echo_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timed_out_o,
    output logic [CNT_WIDTH-1:0] tof_o
);

    localparam logic [CNT_WIDTH-1:0] MaxCount   = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [CNT_WIDTH-1:0] BlankCount = CNT_WIDTH'(BLANK_CYCLES);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] elapsed_q;
    logic [CNT_WIDTH-1:0] elapsed_d;
    logic [CNT_WIDTH-1:0] riseAt_q;
    logic                 qualClear;
    logic                 qualEnable;
    logic                 listening;
    logic                 risePulse;
    logic                 accept;

    assign elapsed_d  = elapsed_q + CNT_WIDTH'(1);
    assign qualClear  = (state_q == IDLE) && start_i;
    assign qualEnable = (state_q != IDLE);
    assign listening  = (state_q == LISTEN);

    echo_qualifier #(
        .ECHO_MIN(ECHO_MIN)
    ) u_qualifier (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (qualClear),
        .enable_i    (qualEnable),
        .eligible_i  (listening),
        .echo_i      (echo_i),
        .rise_pulse_o(risePulse),
        .accept_o    (accept)
    );

    // elapsed_d is the count k belonging to the current edge; tof reports the rise edge's k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            elapsed_q   <= '0;
            riseAt_q    <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timed_out_o <= 1'b0;
            tof_o       <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= (BLANK_CYCLES == 0) ? LISTEN : BLANK;
                        elapsed_q   <= '0;
                        busy_o      <= 1'b1;
                        tof_o       <= '0;
                        timed_out_o <= 1'b0;
                    end
                end
                BLANK, LISTEN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        elapsed_q <= elapsed_d;
                        if (risePulse) begin
                            riseAt_q <= elapsed_d;
                        end
                        if (accept) begin
                            tof_o       <= risePulse ? elapsed_d : riseAt_q;
                            timed_out_o <= 1'b0;
                            done_o      <= 1'b1;
                            busy_o      <= 1'b0;
                            state_q     <= IDLE;
                        end else if (elapsed_d == MaxCount) begin
                            tof_o       <= MaxCount;
                            timed_out_o <= 1'b1;
                            done_o      <= 1'b1;
                            busy_o      <= 1'b0;
                            state_q     <= IDLE;
                        end else if ((state_q == BLANK) && (elapsed_d == BlankCount)) begin
                            state_q <= LISTEN;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tof_echo_timer.md
Name: tof_echo_timer

Overview:
- Receiving end of the ultrasound time-of-flight path. The delay line applies a known delay; this block measures an unknown one.
- Counts clk cycles from a transmit-start pulse to the first qualified rising edge of the echo-detect signal, then reports the elapsed count.
- Supports a blanking window (ignores transmit ringing), minimum echo-width qualification (glitch rejection), timeout and abort.
- Sits between the echo comparator/synchronizer and the measurement readout logic.

Parameters:
- CNT_WIDTH, 24: width of the elapsed counter and of tof.
- BLANK_CYCLES, 100: elapsed counts 1..BLANK_CYCLES are ignored for edge detection.
- ECHO_MIN, 3: consecutive high samples required to accept an echo (>=1).
- MAX_CYCLES, 1000000: timeout count. Legal ranges: BLANK_CYCLES < MAX_CYCLES <= 2^CNT_WIDTH-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle transmit-start strobe
- abort  in  1  cancel the measurement in progress
- echo  in  1  echo detect, already synchronous to clk
- busy  out  1  measurement in progress
- done  out  1  one-cycle pulse at measurement end
- timed_out  out  1  last measurement ended by timeout
- tof  out  CNT_WIDTH  measured elapsed count

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous, active-high.
- On rst: state IDLE; busy=0, done=0, timed_out=0, tof=0; counters and echo history are 0. Outputs clear immediately when rst asserts, including mid-measurement.
- States and transitions:
  - IDLE: start=1 at edge E0 -> BLANK; elapsed k=0; echo history prev<=echo; tof<=0; timed_out<=0.
  - BLANK and LISTEN: k increments at every edge E1, E2, ... Echo is sampled at edge Ek with elapsed value k.
  - BLANK -> LISTEN at the edge where k=BLANK_CYCLES. prev keeps tracking echo during BLANK. No rise is eligible while k<=BLANK_CYCLES.
- Rise detection: echo=1 at Ek and prev=0 (echo value at Ek-1), with k>BLANK_CYCLES. An echo already high when blanking ends is not a rise; it must fall and rise again.
- Qualification:
  - The candidate run starts at Ek. The run counter counts consecutive high samples.
  - Accept when echo=1 at Ek..Ek+ECHO_MIN-1.
  - If echo is low before the run completes, discard the candidate and keep listening.
  - ECHO_MIN=1 accepts on the rise edge itself.
- Acceptance at edge Ek+ECHO_MIN-1: tof<=k (rise time, not acceptance time); timed_out<=0; done=1 for exactly one cycle; state -> IDLE; busy=0 in the same cycle done is high.
- Timeout: if k reaches MAX_CYCLES with no acceptance at that edge -> tof<=MAX_CYCLES, timed_out<=1, done pulse, -> IDLE. If acceptance and timeout fall on the same edge, acceptance wins.
- Abort: abort=1 in BLANK/LISTEN -> IDLE at that edge. No done pulse. tof and timed_out stay at their start-cleared values (0). abort in IDLE is ignored.
- Input precedence:
  - start in BLANK/LISTEN is ignored; no restart.
  - start and abort together in IDLE: start wins.
  - start and abort together while busy: abort wins.
- tof and timed_out hold until the next accepted start. done is registered; results are valid in the same cycle done is high.
- Latency: done is asserted the cycle after edge Ek+ECHO_MIN-1 (registered outputs).
- busy=1 exactly while in BLANK or LISTEN.
- Width: k saturation is unnecessary because k never exceeds MAX_CYCLES. The run counter is $clog2(ECHO_MIN+1) bits.

Decomposition:
- Package tof_pkg: state enum typedef (IDLE, BLANK, LISTEN) and a shared elapsed-count width default constant.
- Sub-module echo_qualifier: holds the prev register and run counter; provides sync clear and enable inputs; outputs rise_pulse and accept.
- The top level holds the FSM, the elapsed counter and the result registers.

Test Plan (CNT_WIDTH=8, BLANK_CYCLES=4, ECHO_MIN=3, MAX_CYCLES=20):
1. start at E0; echo high from k=8 onward -> done one cycle after E10; tof=8; timed_out=0; busy falls together with done.
2. echo high k=2..6, low k=7, high from k=9 -> blanked run ignored; tof=9.
3. echo high k=8..9, low k=10, high from k=12 -> glitch rejected; tof=12.
4. echo never high -> done after E20; tof=20; timed_out=1. Then a new start clears tof=0 and timed_out=0 at its E0.
5. Rise at k=18, held -> acceptance at k=20 coincides with timeout; tof=18; timed_out=0.
6. Two sub-cases:
   - start pulsed again at k=3 -> ignored; abort at k=6 -> busy=0 next cycle, no done.
   - rst asserted mid-LISTEN -> all outputs 0 asynchronously; the next start measures normally.
